// File: rtl/exc_ctrl_pkg.sv
// Shared system register definitions for the exception controller:
// exception flag map, cause codes, vector and CP0 register addresses.
package exc_ctrl_pkg;

   localparam int EXC_W    = 7;
   localparam int EXC_ERET = 6;
   localparam int EXC_BRK  = 5;
   localparam int EXC_SYS  = 4;
   localparam int EXC_OV   = 3;
   localparam int EXC_RI   = 2;

   // Address-error kind, carried in mem_exc_i[1:0]
   typedef enum logic [1:0] {
      AD_NONE  = 2'b00,
      AD_FETCH = 2'b01,
      AD_LOAD  = 2'b10,
      AD_STORE = 2'b11
   } ad_e;

   typedef enum logic [4:0] {
      EC_INT  = 5'h00,
      EC_ADEL = 5'h04,
      EC_ADES = 5'h05,
      EC_SYS  = 5'h08,
      EC_BP   = 5'h09,
      EC_RI   = 5'h0a,
      EC_OV   = 5'h0c
   } exc_code_e;

   localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;

   localparam logic [1:0] DRAIN_CYCLES = 2'd2;

   typedef enum logic {
      S_IDLE,
      S_DRAIN
   } state_e;

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 side bundle of the exception controller.
// slave = controller side, master = pipeline/CP0 side.
interface exc_ctrl_if;
   import exc_ctrl_pkg::*;

   logic             mem_valid_i;
   logic [31:0]      mem_pc_i;
   logic             mem_bd_i;
   logic [EXC_W-1:0] mem_exc_i;
   logic [31:0]      mem_badvaddr_i;
   logic [31:0]      cp0_status_i;
   logic [31:0]      cp0_cause_i;
   logic [31:0]      cp0_epc_i;
   logic             timer_int_i;
   logic             wb_cp0_we_i;
   logic [4:0]       wb_cp0_waddr_i;
   logic [31:0]      wb_cp0_wdata_i;

   logic             flush_o;
   logic [31:0]      new_pc_o;
   logic             exc_we_o;
   logic [4:0]       exc_code_o;
   logic [31:0]      exc_epc_o;
   logic             exc_bd_o;
   logic [31:0]      exc_badvaddr_o;
   logic             exc_badvaddr_we_o;
   logic             eret_o;
   logic             busy_o;

   modport slave (
      input  mem_valid_i, mem_pc_i, mem_bd_i, mem_exc_i,
      input  mem_badvaddr_i,
      input  cp0_status_i, cp0_cause_i, cp0_epc_i,
      input  timer_int_i,
      input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
      output flush_o, new_pc_o, exc_we_o, exc_code_o,
      output exc_epc_o, exc_bd_o, exc_badvaddr_o,
      output exc_badvaddr_we_o, eret_o, busy_o
   );

   modport master (
      output mem_valid_i, mem_pc_i, mem_bd_i, mem_exc_i,
      output mem_badvaddr_i,
      output cp0_status_i, cp0_cause_i, cp0_epc_i,
      output timer_int_i,
      output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
      input  flush_o, new_pc_o, exc_we_o, exc_code_o,
      input  exc_epc_o, exc_bd_o, exc_badvaddr_o,
      input  exc_badvaddr_we_o, eret_o, busy_o
   );

endinterface

// File: rtl/exc_ctrl_prio.sv
// CP0 bypass, interrupt pending and exception priority encoder.
// Purely combinational; en gates every event.
module exc_prio
   import exc_ctrl_pkg::*;
(
   input  logic             en,
   input  logic             int_req,
   input  logic [31:0]      pc,
   input  logic             bd,
   input  logic [EXC_W-1:0] exc,
   input  logic [31:0]      badvaddr,
   input  logic [31:0]      status,
   input  logic [31:0]      cause,
   input  logic [31:0]      epc,
   input  logic             timer_int,
   input  logic             wb_we,
   input  logic [4:0]       wb_waddr,
   input  logic [31:0]      wb_wdata,
   output logic             int_pend,
   output logic             take_int,
   output logic             take_exc,
   output logic             take_eret,
   output exc_code_e        code,
   output logic             bva_we,
   output logic [31:0]      bva,
   output logic [31:0]      exc_epc,
   output logic [31:0]      eff_epc
);

   logic [31:0] eff_status;
   logic [1:0]  eff_sw_ip;
   logic [7:0]  ip;
   ad_e         ad;
   logic        unused_cp0;

   assign eff_status = (wb_we && wb_waddr == CP0_STATUS) ? wb_wdata : status;
   assign eff_epc    = (wb_we && wb_waddr == CP0_EPC)    ? wb_wdata : epc;
   assign eff_sw_ip  = (wb_we && wb_waddr == CP0_CAUSE)
                     ? wb_wdata[9:8] : cause[9:8];

   assign ip = {cause[15] | timer_int, cause[14:10], eff_sw_ip};

   assign int_pend = eff_status[ST_IE] & ~eff_status[ST_EXL]
                   & |(eff_status[15:8] & ip);

   assign unused_cp0 = ^{status[31:16], status[7:2],
                         cause[31:16], cause[7:0]};

   assign ad = ad_e'(exc[1:0]);

   // Nested exception keeps the EPC already held by CP0
   assign exc_epc = eff_status[ST_EXL] ? eff_epc
                  : (bd ? pc - 32'd4 : pc);

   always_comb begin
      take_exc  = 1'b0;
      take_eret = 1'b0;
      code      = EC_INT;
      bva_we    = 1'b0;
      bva       = badvaddr;
      if (en) begin
         priority case (1'b1)
            int_req: begin
               take_exc = 1'b1;
               code     = EC_INT;
            end
            (ad == AD_FETCH): begin
               take_exc = 1'b1;
               code     = EC_ADEL;
               bva_we   = 1'b1;
               bva      = pc;
            end
            exc[EXC_RI]: begin
               take_exc = 1'b1;
               code     = EC_RI;
            end
            exc[EXC_OV]: begin
               take_exc = 1'b1;
               code     = EC_OV;
            end
            exc[EXC_SYS]: begin
               take_exc = 1'b1;
               code     = EC_SYS;
            end
            exc[EXC_BRK]: begin
               take_exc = 1'b1;
               code     = EC_BP;
            end
            (ad == AD_LOAD): begin
               take_exc = 1'b1;
               code     = EC_ADEL;
               bva_we   = 1'b1;
            end
            (ad == AD_STORE): begin
               take_exc = 1'b1;
               code     = EC_ADES;
               bva_we   = 1'b1;
            end
            exc[EXC_ERET]: take_eret = 1'b1;
            default: ;
         endcase
      end
   end

   assign take_int = take_exc & (code == EC_INT);

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: registers the winning MEM-stage event into
// flush/commit pulses and drains the pipeline for two cycles.
module exc_ctrl
   import exc_ctrl_pkg::*;
(
   input logic       clk,
   input logic       rst,
   exc_ctrl_if.slave bus
);

   state_e      state;
   logic [1:0]  drain_cnt;
   logic        int_req;
   logic        en;
   logic        int_pend;
   logic        take_int;
   logic        take_exc;
   logic        take_eret;
   exc_code_e   code;
   logic        bva_we;
   logic [31:0] bva;
   logic [31:0] exc_epc;
   logic [31:0] eff_epc;

   assign en = bus.mem_valid_i & (state == S_IDLE);

   exc_prio u_prio (
      .en        (en),
      .int_req   (int_req),
      .pc        (bus.mem_pc_i),
      .bd        (bus.mem_bd_i),
      .exc       (bus.mem_exc_i),
      .badvaddr  (bus.mem_badvaddr_i),
      .status    (bus.cp0_status_i),
      .cause     (bus.cp0_cause_i),
      .epc       (bus.cp0_epc_i),
      .timer_int (bus.timer_int_i),
      .wb_we     (bus.wb_cp0_we_i),
      .wb_waddr  (bus.wb_cp0_waddr_i),
      .wb_wdata  (bus.wb_cp0_wdata_i),
      .int_pend  (int_pend),
      .take_int  (take_int),
      .take_exc  (take_exc),
      .take_eret (take_eret),
      .code      (code),
      .bva_we    (bva_we),
      .bva       (bva),
      .exc_epc   (exc_epc),
      .eff_epc   (eff_epc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= S_IDLE;
         drain_cnt             <= '0;
         int_req               <= 1'b0;
         bus.flush_o           <= 1'b0;
         bus.exc_we_o          <= 1'b0;
         bus.eret_o            <= 1'b0;
         bus.exc_badvaddr_we_o <= 1'b0;
         bus.busy_o            <= 1'b0;
         bus.new_pc_o          <= '0;
         bus.exc_epc_o         <= '0;
         bus.exc_badvaddr_o    <= '0;
         bus.exc_code_o        <= '0;
         bus.exc_bd_o          <= 1'b0;
      end else begin
         int_req               <= int_pend & ~take_int;
         bus.flush_o           <= take_exc | take_eret;
         bus.exc_we_o          <= take_exc;
         bus.eret_o            <= take_eret;
         bus.exc_badvaddr_we_o <= take_exc & bva_we;

         if (take_exc) begin
            bus.new_pc_o   <= EXC_VECTOR;
            bus.exc_code_o <= code;
            bus.exc_epc_o  <= exc_epc;
            bus.exc_bd_o   <= bus.mem_bd_i;
            if (bva_we) begin
               bus.exc_badvaddr_o <= bva;
            end
         end else if (take_eret) begin
            bus.new_pc_o <= eff_epc;
         end

         case (state)
            S_IDLE: begin
               if (take_exc | take_eret) begin
                  state      <= S_DRAIN;
                  drain_cnt  <= '0;
                  bus.busy_o <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DRAIN_CYCLES - 2'd1) begin
                  state      <= S_IDLE;
                  bus.busy_o <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_exc_ctrl;
   import exc_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   exc_ctrl_if bus ();

   exc_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   int          drain_left;
   bit          m_int_req;
   logic        e_flush, e_we, e_eret, e_bvwe, e_busy, e_bd;
   logic [31:0] e_pc, e_epc, e_bva;
   logic [4:0]  e_code;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic idle_in();
      bus.mem_valid_i    = 1'b0;
      bus.mem_pc_i       = '0;
      bus.mem_bd_i       = 1'b0;
      bus.mem_exc_i      = '0;
      bus.mem_badvaddr_i = '0;
      bus.cp0_status_i   = '0;
      bus.cp0_cause_i    = '0;
      bus.cp0_epc_i      = '0;
      bus.timer_int_i    = 1'b0;
      bus.wb_cp0_we_i    = 1'b0;
      bus.wb_cp0_waddr_i = '0;
      bus.wb_cp0_wdata_i = '0;
   endtask

   // Advance one clock: predict from the driven inputs, then compare.
   task automatic cycle();
      logic [31:0] st, ca, ep, pc;
      logic [7:0]  ip;
      logic [6:0]  f;
      bit          pend;
      bit          cond [9];
      logic [4:0]  code_of [9] = '{5'h00, 5'h04, 5'h0a, 5'h0c,
                                   5'h08, 5'h09, 5'h04, 5'h05, 5'h00};
      int          sel;
      if (rst) begin
         drain_left = 0;
         m_int_req  = 0;
         {e_flush, e_we, e_eret, e_bvwe, e_busy, e_bd} = '0;
         e_pc   = '0;
         e_epc  = '0;
         e_bva  = '0;
         e_code = '0;
      end else begin
         st = bus.cp0_status_i;
         ca = bus.cp0_cause_i;
         ep = bus.cp0_epc_i;
         if (bus.wb_cp0_we_i) begin
            if (bus.wb_cp0_waddr_i == 5'd12) st = bus.wb_cp0_wdata_i;
            if (bus.wb_cp0_waddr_i == 5'd13) ca[9:8] = bus.wb_cp0_wdata_i[9:8];
            if (bus.wb_cp0_waddr_i == 5'd14) ep = bus.wb_cp0_wdata_i;
         end
         ip   = {ca[15] | bus.timer_int_i, ca[14:8]};
         pend = st[0] && !st[1] && ((st[15:8] & ip) != 8'd0);
         f    = bus.mem_exc_i;
         pc   = bus.mem_pc_i;
         cond = '{m_int_req, f[1:0] == 2'b01, f[2], f[3], f[4], f[5],
                  f[1:0] == 2'b10, f[1:0] == 2'b11, f[6]};
         sel = -1;
         if (bus.mem_valid_i && drain_left == 0) begin
            for (int i = 0; i < 9; i++) begin
               if (cond[i] && sel < 0) sel = i;
            end
         end
         e_flush = (sel >= 0);
         e_we    = (sel >= 0 && sel < 8);
         e_eret  = (sel == 8);
         e_bvwe  = (sel == 1 || sel == 6 || sel == 7);
         if (e_we) begin
            e_pc   = 32'hBFC0_0380;
            e_code = code_of[sel];
            e_bd   = bus.mem_bd_i;
            e_epc  = st[1] ? ep : (bus.mem_bd_i ? pc - 32'd4 : pc);
         end
         if (sel == 1) e_bva = pc;
         if (sel == 6 || sel == 7) e_bva = bus.mem_badvaddr_i;
         if (e_eret) e_pc = ep;
         m_int_req = pend && sel != 0;
         if (sel >= 0) drain_left = 2;
         else if (drain_left > 0) drain_left--;
         e_busy = (drain_left > 0);
      end
      @(posedge clk);
      @(negedge clk);
      chk("flush", 32'(bus.flush_o), 32'(e_flush));
      chk("exc_we", 32'(bus.exc_we_o), 32'(e_we));
      chk("eret", 32'(bus.eret_o), 32'(e_eret));
      chk("bva_we", 32'(bus.exc_badvaddr_we_o), 32'(e_bvwe));
      chk("busy", 32'(bus.busy_o), 32'(e_busy));
      chk("new_pc", bus.new_pc_o, e_pc);
      chk("code", 32'(bus.exc_code_o), 32'(e_code));
      chk("epc", bus.exc_epc_o, e_epc);
      chk("bd", 32'(bus.exc_bd_o), 32'(e_bd));
      chk("badvaddr", bus.exc_badvaddr_o, e_bva);
   endtask

   task automatic idle_n(int n);
      idle_in();
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      cycle();
      cycle();
      chk("rst_flush", 32'(bus.flush_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_pc", bus.new_pc_o, 32'd0);
      rst = 1'b0;
      idle_n(1);

      // syscall, EXL=0
      bus.mem_valid_i = 1'b1;
      bus.mem_pc_i    = 32'h8000_0100;
      bus.mem_exc_i[EXC_SYS] = 1'b1;
      cycle();
      chk("sys_flush", 32'(bus.flush_o), 32'd1);
      chk("sys_pc", bus.new_pc_o, 32'hBFC0_0380);
      chk("sys_code", 32'(bus.exc_code_o), 32'h08);
      chk("sys_epc", bus.exc_epc_o, 32'h8000_0100);
      idle_n(1);
      chk("sys_busy2", 32'(bus.busy_o), 32'd1);
      idle_n(1);
      chk("sys_busy3", 32'(bus.busy_o), 32'd0);

      // overflow in delay slot
      bus.mem_valid_i = 1'b1;
      bus.mem_pc_i    = 32'h8000_0204;
      bus.mem_bd_i    = 1'b1;
      bus.mem_exc_i[EXC_OV] = 1'b1;
      cycle();
      chk("ov_epc", bus.exc_epc_o, 32'h8000_0200);
      chk("ov_bd", 32'(bus.exc_bd_o), 32'd1);
      chk("ov_code", 32'(bus.exc_code_o), 32'h0c);
      idle_n(3);

      // timer interrupt beats RI
      bus.cp0_status_i = 32'h0000_8001;
      bus.timer_int_i  = 1'b1;
      cycle();
      bus.mem_valid_i = 1'b1;
      bus.mem_pc_i    = 32'h8000_0300;
      bus.mem_exc_i[EXC_RI] = 1'b1;
      cycle();
      chk("int_code", 32'(bus.exc_code_o), 32'h00);
      chk("int_we", 32'(bus.exc_we_o), 32'd1);
      idle_n(3);

      // ERET with EPC bypassed from WB
      bus.mem_valid_i    = 1'b1;
      bus.mem_exc_i[EXC_ERET] = 1'b1;
      bus.cp0_epc_i      = 32'h1234_5678;
      bus.wb_cp0_we_i    = 1'b1;
      bus.wb_cp0_waddr_i = CP0_EPC;
      bus.wb_cp0_wdata_i = 32'h8000_0400;
      cycle();
      chk("eret_pc", bus.new_pc_o, 32'h8000_0400);
      chk("eret_p", 32'(bus.eret_o), 32'd1);
      chk("eret_we", 32'(bus.exc_we_o), 32'd0);
      idle_n(3);

      // back-to-back syscall, second lands in drain
      bus.mem_valid_i = 1'b1;
      bus.mem_pc_i    = 32'h8000_0500;
      bus.mem_exc_i[EXC_SYS] = 1'b1;
      cycle();
      bus.mem_pc_i = 32'h8000_0504;
      cycle();
      chk("b2b_we", 32'(bus.exc_we_o), 32'd0);
      idle_n(2);

      // AdES
      bus.mem_valid_i    = 1'b1;
      bus.mem_exc_i      = 7'(AD_STORE);
      bus.mem_badvaddr_i = 32'h0000_0003;
      cycle();
      chk("ades_bva", bus.exc_badvaddr_o, 32'h0000_0003);
      chk("ades_code", 32'(bus.exc_code_o), 32'h05);
      chk("ades_we", 32'(bus.exc_badvaddr_we_o), 32'd1);
      idle_n(3);

      // nested: EXL=1 keeps EPC
      bus.mem_valid_i  = 1'b1;
      bus.mem_pc_i     = 32'h8000_0600;
      bus.cp0_status_i = 32'h0000_0002;
      bus.cp0_epc_i    = 32'hCAFE_0000;
      bus.mem_exc_i[EXC_BRK] = 1'b1;
      cycle();
      chk("exl_epc", bus.exc_epc_o, 32'hCAFE_0000);
      chk("exl_code", 32'(bus.exc_code_o), 32'h09);
      idle_n(3);

      // reset during drain
      bus.mem_valid_i = 1'b1;
      bus.mem_pc_i    = 32'h8000_0700;
      bus.mem_exc_i[EXC_SYS] = 1'b1;
      cycle();
      rst = 1'b1;
      idle_n(1);
      chk("rst_dr_flush", 32'(bus.flush_o), 32'd0);
      chk("rst_dr_we", 32'(bus.exc_we_o), 32'd0);
      chk("rst_dr_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_dr_pc", bus.new_pc_o, 32'd0);

      // reset coincident with detection
      bus.mem_valid_i = 1'b1;
      bus.mem_exc_i[EXC_SYS] = 1'b1;
      cycle();
      chk("rst_co_flush", 32'(bus.flush_o), 32'd0);
      rst = 1'b0;
      idle_n(1);

      for (int n = 0; n < 500; n++) begin
         rst = ($urandom_range(59) == 0);
         bus.mem_valid_i    = ($urandom_range(3) != 0);
         bus.mem_pc_i       = $urandom;
         bus.mem_bd_i       = 1'($urandom);
         bus.mem_exc_i      = ($urandom_range(2) == 0) ? 7'($urandom) : 7'd0;
         bus.mem_badvaddr_i = $urandom;
         bus.cp0_status_i   = $urandom;
         bus.cp0_cause_i    = $urandom;
         bus.cp0_epc_i      = $urandom;
         bus.timer_int_i    = 1'($urandom);
         bus.wb_cp0_we_i    = 1'($urandom);
         bus.wb_cp0_waddr_i = 5'(12 + $urandom_range(3));
         bus.wb_cp0_wdata_i = $urandom;
         cycle();
      end
      rst = 1'b0;
      idle_n(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
